// File: rtl/nrzi_decoder.sv
// nrzi_decoder
//   Receive-side NRZI line decoder with bit-stuffing removal. The line holds
//   its level for a data 1 and toggles for a data 0. After STUFF_LEN decoded
//   1s in a row, the next line bit must be a stuffed 0. That bit is dropped.
//   A 1 in the stuffed position is dropped as well and flagged on stuff_err.
//
//   Optional feature (macro NRZI_DESER_EN): an LSB-first deserialiser packs
//   the emitted data bits into WORD_W-bit words. When the macro is undefined,
//   word and word_valid are tied to 0.
//
// Parameters
//   STUFF_LEN   run of decoded 1s that forces a stuffed 0 (1..15)
//   IDLE_LEVEL  line level assumed before the first bit
//   WORD_W      deserialiser width, must be at least 2 (NRZI_DESER_EN only)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   din         sampled line level
//   din_valid   one line bit per asserted cycle
//   clr         synchronous resync at a packet boundary; same effect as rst
//   dout        decoded data bit; holds between valid pulses
//   dout_valid  1-cycle qualifier for dout
//   stuff_err   1-cycle pulse on a stuffing violation
//   word        deserialised word, LSB = first bit received
//   word_valid  1-cycle qualifier for word
module nrzi_decoder #(
  parameter int unsigned STUFF_LEN  = 6,
  parameter bit          IDLE_LEVEL = 1'b1,
  parameter int unsigned WORD_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              clr,
  output logic              dout,
  output logic              dout_valid,
  output logic              stuff_err,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int unsigned     CW      = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0]   C_STUFF = CW'(STUFF_LEN);

  typedef enum logic {S_DATA, S_STUFF} state_t;

  state_t          r_state;
  logic            r_prev_lvl;
  logic [CW-1:0]   r_ones_cnt;
  logic            r_dout;
  logic            r_dout_valid;
  logic            r_stuff_err;

  logic            w_sync;      // rst or clr: both return to the idle state
  logic            w_raw;       // decoded bit before stuffing removal
  logic [CW-1:0]   w_ones_inc;
  logic            w_emit;      // this bit is passed on as data

  assign w_sync     = rst | clr;
  assign w_raw      = (din == r_prev_lvl);
  assign w_ones_inc = r_ones_cnt + CW'(1);
  assign w_emit     = din_valid && (r_state == S_DATA);

  always_ff @(posedge clk) begin
    if (w_sync) begin
      r_state      <= S_DATA;
      r_prev_lvl   <= IDLE_LEVEL;
      r_ones_cnt   <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_stuff_err  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_stuff_err  <= 1'b0;
      if (din_valid) begin
        r_prev_lvl <= din;
        case (r_state)
          S_DATA: begin
            r_dout       <= w_raw;
            r_dout_valid <= 1'b1;
            if (w_raw) begin
              r_ones_cnt <= w_ones_inc;
              if (w_ones_inc == C_STUFF) r_state <= S_STUFF;
            end else begin
              r_ones_cnt <= '0;
            end
          end
          S_STUFF: begin
            // The stuffed position is dropped either way. A 1 here means
            // the sender broke the stuffing rule.
            r_stuff_err <= w_raw;
            r_ones_cnt  <= '0;
            r_state     <= S_DATA;
          end
          default: r_state <= S_DATA;
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign stuff_err  = r_stuff_err;

`ifdef NRZI_DESER_EN
  localparam int unsigned   BW      = $clog2(WORD_W);
  localparam logic [BW-1:0] BC_LAST = BW'(WORD_W - 1);

  logic [WORD_W-1:0] r_word;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_word_valid;

  // Shift in at the MSB. After WORD_W shifts, the first bit sits at the LSB.
  always_ff @(posedge clk) begin
    if (w_sync) begin
      r_word       <= '0;
      r_bit_cnt    <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (w_emit) begin
        r_word <= {w_raw, r_word[WORD_W-1:1]};
        if (r_bit_cnt == BC_LAST) begin
          r_bit_cnt    <= '0;
          r_word_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
    end
  end

  assign word       = r_word;
  assign word_valid = r_word_valid;
`else
  logic w_unused;
  assign w_unused   = w_emit;
  assign word       = '0;
  assign word_valid = 1'b0;
`endif

endmodule
